// File: rtl/mips_inst_encoder_if.sv
// rtl/mips_inst_encoder_if.sv - command and word-stream bundle for the MIPS instruction encoder
interface mips_inst_encoder_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_kind;
  logic [3:0]  in_aluc;
  logic [3:0]  in_jmp;
  logic [4:0]  in_ra;
  logic [4:0]  in_rb;
  logic [4:0]  in_rn;
  logic [31:0] in_imm;
  logic        in_useimm;
  logic [31:0] in_pc;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_inst;
  logic [31:0] out_pc;
  logic        out_last;
  logic        err;
  logic [1:0]  err_code;

  modport master (
    output in_valid, in_kind, in_aluc, in_jmp, in_ra, in_rb, in_rn, in_imm, in_useimm, in_pc,
    output out_ready,
    input  in_ready, out_valid, out_inst, out_pc, out_last, err, err_code
  );

  modport slave (
    input  in_valid, in_kind, in_aluc, in_jmp, in_ra, in_rb, in_rn, in_imm, in_useimm, in_pc,
    input  out_ready,
    output in_ready, out_valid, out_inst, out_pc, out_last, err, err_code
  );
endinterface

// File: rtl/mips_inst_encoder.sv
// rtl/mips_inst_encoder.sv - micro-op to MIPS-I word encoder with LUI/ORI expansion through $at
module mips_inst_encoder #(
  parameter int AT_REG    = 1,
  parameter int MAX_WORDS = 4
) (
  input logic                clk,
  input logic                rst,
  mips_inst_encoder_if.slave bus
);
  localparam int         IW = $clog2(MAX_WORDS);
  localparam int         CW = $clog2(MAX_WORDS + 1);
  localparam logic [4:0] AT = AT_REG[4:0];

  localparam logic [2:0] K_ALU = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2, K_BRANCH = 3'd3;
  localparam logic [2:0] K_JUMP = 3'd4, K_JAL = 3'd5, K_JR = 3'd6;
  localparam logic [3:0] A_ADD = 4'b0000, A_OR = 4'b0101;
  localparam logic [5:0] OP_J = 6'h02, OP_JAL = 6'h03, OP_BEQ = 6'h04, OP_BNE = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ANDI = 6'h0C, OP_ORI = 6'h0D, OP_XORI = 6'h0E;
  localparam logic [5:0] OP_LUI = 6'h0F, OP_LW = 6'h23, OP_SW = 6'h2B;

  typedef enum logic [0:0] {S_IDLE, S_EMIT} state_t;

  function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                         input logic [4:0] rd, input logic [4:0] sa,
                                         input logic [5:0] fn);
    return {6'h00, rs, rt, rd, sa, fn};
  endfunction

  function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                         input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  state_t          state_q, state_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_inst_q, out_inst_d;
  logic [31:0]     out_pc_q, out_pc_d;
  logic            out_last_q, out_last_d;
  logic            err_q, err_d;
  logic [1:0]      err_code_q, err_code_d;
  logic [31:0]     word_q [MAX_WORDS];
  logic [31:0]     word_d [MAX_WORDS];
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [IW-1:0]   idx_q, idx_d, idx_nxt;

  logic [5:0]      alu_fn, alu_iop;
  logic            alu_ok, alu_shift, alu_has_iop;
  logic [15:0]     imm_hi, imm_lo;
  logic            imm_s16;
  logic [31:0]     pc4;
  logic [29:0]     br_off;
  logic            br_fits;
  logic            is_store;
  logic [5:0]      mem_op;
  logic [4:0]      mem_rt;

  logic [31:0]     enc_w [4];
  logic [CW-1:0]   enc_n;
  logic            enc_err;
  logic [1:0]      enc_code;

  always_comb begin
    alu_fn      = 6'h00;
    alu_iop     = 6'h00;
    alu_ok      = 1'b1;
    alu_shift   = 1'b0;
    alu_has_iop = 1'b0;
    case (bus.in_aluc)
      4'b0000: alu_fn = 6'h20;
      4'b0100: alu_fn = 6'h22;
      4'b0001: begin alu_fn = 6'h24; alu_iop = OP_ANDI; alu_has_iop = 1'b1; end
      4'b0101: begin alu_fn = 6'h25; alu_iop = OP_ORI;  alu_has_iop = 1'b1; end
      4'b0010: begin alu_fn = 6'h26; alu_iop = OP_XORI; alu_has_iop = 1'b1; end
      4'b0011: begin alu_fn = 6'h00; alu_shift = 1'b1; end
      4'b0111: begin alu_fn = 6'h02; alu_shift = 1'b1; end
      4'b1111: begin alu_fn = 6'h03; alu_shift = 1'b1; end
      default: alu_ok = 1'b0;
    endcase
  end

  assign imm_hi   = bus.in_imm[31:16];
  assign imm_lo   = bus.in_imm[15:0];
  assign imm_s16  = (bus.in_imm[31:15] == {17{bus.in_imm[15]}});
  assign pc4      = bus.in_pc + 32'd4;
  assign br_off   = 30'((bus.in_imm - pc4) >> 2);
  assign br_fits  = (br_off[29:15] == {15{br_off[15]}});
  assign is_store = (bus.in_kind == K_STORE);
  assign mem_op   = is_store ? OP_SW : OP_LW;
  assign mem_rt   = is_store ? bus.in_rb : bus.in_rn;

  // Encode the whole command up front so IDLE can load the buffer in one cycle.
  always_comb begin
    enc_n    = CW'(1);
    enc_err  = 1'b0;
    enc_code = 2'd0;
    for (int i = 0; i < 4; i++) enc_w[i] = '0;
    case (bus.in_kind)
      K_ALU: begin
        if (!alu_ok || (alu_shift && !bus.in_useimm)) begin
          enc_err = 1'b1; enc_code = 2'd3;
        end else if (alu_shift) begin
          enc_w[0] = r_type(5'd0, bus.in_ra, bus.in_rn, bus.in_imm[4:0], alu_fn);
        end else if (!bus.in_useimm) begin
          enc_w[0] = r_type(bus.in_ra, bus.in_rb, bus.in_rn, 5'd0, alu_fn);
        end else if (bus.in_aluc == A_ADD && imm_s16) begin
          enc_w[0] = i_type(OP_ADDI, bus.in_ra, bus.in_rn, imm_lo);
        end else if (alu_has_iop && imm_hi == 16'h0000) begin
          enc_w[0] = i_type(alu_iop, bus.in_ra, bus.in_rn, imm_lo);
        end else if (bus.in_aluc == A_OR && bus.in_ra == 5'd0 && imm_lo == 16'h0000) begin
          enc_w[0] = i_type(OP_LUI, 5'd0, bus.in_rn, imm_hi);
        end else if (bus.in_ra == AT || bus.in_rn == AT) begin
          enc_err = 1'b1; enc_code = 2'd3;
        end else begin
          enc_n    = CW'(3);
          enc_w[0] = i_type(OP_LUI, 5'd0, AT, imm_hi);
          enc_w[1] = i_type(OP_ORI, AT, AT, imm_lo);
          enc_w[2] = r_type(bus.in_ra, AT, bus.in_rn, 5'd0, alu_fn);
        end
      end
      K_LOAD, K_STORE: begin
        if (imm_s16) begin
          enc_w[0] = i_type(mem_op, bus.in_ra, mem_rt, imm_lo);
        end else if (bus.in_ra == AT || bus.in_rn == AT || (is_store && bus.in_rb == AT)) begin
          enc_err = 1'b1; enc_code = 2'd3;
        end else begin
          enc_n    = CW'(4);
          enc_w[0] = i_type(OP_LUI, 5'd0, AT, imm_hi);
          enc_w[1] = i_type(OP_ORI, AT, AT, imm_lo);
          enc_w[2] = r_type(AT, bus.in_ra, AT, 5'd0, 6'h20);
          enc_w[3] = i_type(mem_op, AT, mem_rt, 16'h0000);
        end
      end
      K_BRANCH: begin
        if (bus.in_jmp != 4'd7 && bus.in_jmp != 4'd8) begin
          enc_err = 1'b1; enc_code = 2'd3;
        end else if (bus.in_imm[1:0] != 2'b00) begin
          enc_err = 1'b1; enc_code = 2'd2;
        end else if (!br_fits) begin
          enc_err = 1'b1; enc_code = 2'd1;
        end else begin
          enc_w[0] = i_type((bus.in_jmp == 4'd7) ? OP_BEQ : OP_BNE,
                            bus.in_ra, bus.in_rb, br_off[15:0]);
        end
      end
      K_JUMP, K_JAL: begin
        if (bus.in_imm[1:0] != 2'b00) begin
          enc_err = 1'b1; enc_code = 2'd2;
        end else if (bus.in_imm[31:28] != pc4[31:28]) begin
          enc_err = 1'b1; enc_code = 2'd1;
        end else begin
          enc_w[0] = {(bus.in_kind == K_JAL) ? OP_JAL : OP_J, bus.in_imm[27:2]};
        end
      end
      K_JR: enc_w[0] = r_type(bus.in_ra, 5'd0, 5'd0, 5'd0, 6'h08);
      default: begin
        enc_err = 1'b1; enc_code = 2'd3;
      end
    endcase
  end

  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    out_inst_d  = out_inst_q;
    out_pc_d    = out_pc_q;
    out_last_d  = out_last_q;
    err_d       = 1'b0;
    err_code_d  = 2'd0;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    for (int i = 0; i < MAX_WORDS; i++) word_d[i] = word_q[i];
    idx_nxt     = idx_q + IW'(1);
    case (state_q)
      S_IDLE: begin
        if (bus.in_valid) begin
          if (enc_err) begin
            err_d      = 1'b1;
            err_code_d = enc_code;
          end else begin
            state_d     = S_EMIT;
            for (int i = 0; i < 4; i++) word_d[i] = enc_w[i];
            cnt_d       = enc_n;
            idx_d       = '0;
            out_valid_d = 1'b1;
            out_inst_d  = enc_w[0];
            out_pc_d    = bus.in_pc;
            out_last_d  = (enc_n == CW'(1));
          end
        end
      end
      S_EMIT: begin
        if (bus.out_ready) begin
          if (out_last_q) begin
            state_d     = S_IDLE;
            out_valid_d = 1'b0;
            out_last_d  = 1'b0;
            cnt_d       = '0;
            idx_d       = '0;
          end else begin
            idx_d      = idx_nxt;
            out_inst_d = word_q[idx_nxt];
            out_pc_d   = out_pc_q + 32'd4;
            out_last_d = (CW'(idx_nxt) == cnt_q - CW'(1));
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      out_valid_q <= 1'b0;
      out_inst_q  <= '0;
      out_pc_q    <= '0;
      out_last_q  <= 1'b0;
      err_q       <= 1'b0;
      err_code_q  <= 2'd0;
      cnt_q       <= '0;
      idx_q       <= '0;
      for (int i = 0; i < MAX_WORDS; i++) word_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      out_inst_q  <= out_inst_d;
      out_pc_q    <= out_pc_d;
      out_last_q  <= out_last_d;
      err_q       <= err_d;
      err_code_q  <= err_code_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      for (int i = 0; i < MAX_WORDS; i++) word_q[i] <= word_d[i];
    end
  end

  assign bus.in_ready  = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out_inst  = out_inst_q;
  assign bus.out_pc    = out_pc_q;
  assign bus.out_last  = out_last_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;
endmodule

// File: tb/tb_mips_inst_encoder.sv
// tb/tb_mips_inst_encoder.sv - scoreboard bench for the MIPS instruction encoder
module tb_mips_inst_encoder;
  localparam logic [2:0] K_ALU = 3'd0, K_LOAD = 3'd1, K_STORE = 3'd2, K_BRANCH = 3'd3;
  localparam logic [2:0] K_JUMP = 3'd4, K_JAL = 3'd5, K_JR = 3'd6, K_BAD = 3'd7;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mips_inst_encoder_if bus();

  mips_inst_encoder #(.AT_REG(1), .MAX_WORDS(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        last;
  } word_t;

  word_t      exp_q[$];
  logic [1:0] err_q[$];
  int         n_checks = 0;
  int         n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, want);
    end
  endtask

  // Word scoreboard: a word is compared when it is offered with out_ready high.
  always @(negedge clk) begin
    if (!rst && bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        check("spurious_word", 32'(exp_q.size()), 32'd1);
      end else begin
        word_t w;
        w = exp_q.pop_front();
        check("word_inst", bus.out_inst, w.inst);
        check("word_pc", bus.out_pc, w.pc);
        check("word_last", 32'(bus.out_last), 32'(w.last));
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && bus.err) begin
      if (err_q.size() == 0) begin
        check("spurious_err", 32'(err_q.size()), 32'd1);
      end else begin
        logic [1:0] c;
        c = err_q.pop_front();
        check("err_code", 32'(bus.err_code), 32'(c));
      end
    end
  end

  task automatic expect_word(input logic [31:0] inst, input logic [31:0] pc, input logic last);
    word_t w;
    w.inst = inst;
    w.pc   = pc;
    w.last = last;
    exp_q.push_back(w);
  endtask

  task automatic send(input logic [2:0] kind, input logic [3:0] aluc, input logic [3:0] jmp,
                      input logic [4:0] ra, input logic [4:0] rb, input logic [4:0] rn,
                      input logic [31:0] imm, input logic useimm, input logic [31:0] pc);
    int t;
    t = 0;
    @(posedge clk); #1;
    bus.in_valid  = 1'b1;
    bus.in_kind   = kind;
    bus.in_aluc   = aluc;
    bus.in_jmp    = jmp;
    bus.in_ra     = ra;
    bus.in_rb     = rb;
    bus.in_rn     = rn;
    bus.in_imm    = imm;
    bus.in_useimm = useimm;
    bus.in_pc     = pc;
    while (!bus.in_ready && t < 100) begin
      @(posedge clk); #1;
      t++;
    end
    check("accept_timeout", 32'(t >= 100), 32'd0);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while ((exp_q.size() != 0 || err_q.size() != 0 || !bus.in_ready) && t < 200) begin
      @(negedge clk);
      t++;
    end
    check("drain_pending", 32'(exp_q.size() + err_q.size()), 32'd0);
    check("drain_ready", 32'(bus.in_ready), 32'd1);
  endtask

  task automatic expect_reject(input logic [1:0] code);
    err_q.push_back(code);
  endtask

  task automatic reject_tail();
    @(negedge clk);
    check("rej_err_pulse", 32'(bus.err), 32'd1);
    check("rej_no_valid", 32'(bus.out_valid), 32'd0);
    @(negedge clk);
    check("rej_err_drop", 32'(bus.err), 32'd0);
    check("rej_no_valid2", 32'(bus.out_valid), 32'd0);
    drain();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int t;
    rst           = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_kind   = '0;
    bus.in_aluc   = '0;
    bus.in_jmp    = '0;
    bus.in_ra     = '0;
    bus.in_rb     = '0;
    bus.in_rn     = '0;
    bus.in_imm    = '0;
    bus.in_useimm = 1'b0;
    bus.in_pc     = '0;
    bus.out_ready = 1'b1;
    #3;
    check("rst_in_ready", 32'(bus.in_ready), 32'd1);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_out_inst", bus.out_inst, 32'd0);
    check("rst_out_pc", bus.out_pc, 32'd0);
    check("rst_out_last", 32'(bus.out_last), 32'd0);
    check("rst_err", 32'(bus.err), 32'd0);
    repeat (2) @(posedge clk);
    #2 rst = 1'b0;

    // Single R-type ADD and in_ready recovery timing
    expect_word(32'h00432020, 32'h0, 1'b1);
    send(K_ALU, 4'b0000, 4'd0, 5'd2, 5'd3, 5'd4, 32'h0, 1'b0, 32'h0);
    @(negedge clk);
    check("add_valid", 32'(bus.out_valid), 32'd1);
    check("add_busy", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    check("add_ready_back", 32'(bus.in_ready), 32'd1);
    check("add_valid_drop", 32'(bus.out_valid), 32'd0);
    drain();

    // ADD with 32-bit immediate: 3-word expansion
    expect_word(32'h3C011234, 32'h40, 1'b0);
    expect_word(32'h34215678, 32'h44, 1'b0);
    expect_word(32'h00412020, 32'h48, 1'b1);
    send(K_ALU, 4'b0000, 4'd0, 5'd2, 5'd0, 5'd4, 32'h12345678, 1'b1, 32'h40);
    drain();

    expect_word(32'h2044FFFB, 32'h80, 1'b1);
    send(K_ALU, 4'b0000, 4'd0, 5'd2, 5'd0, 5'd4, 32'hFFFFFFFB, 1'b1, 32'h80);
    drain();

    // SUB with immediate always expands
    expect_word(32'h3C010000, 32'h300, 1'b0);
    expect_word(32'h34210005, 32'h304, 1'b0);
    expect_word(32'h00412022, 32'h308, 1'b1);
    send(K_ALU, 4'b0100, 4'd0, 5'd2, 5'd0, 5'd4, 32'h5, 1'b1, 32'h300);
    drain();

    expect_word(32'h00074143, 32'h10, 1'b1);
    send(K_ALU, 4'b1111, 4'd0, 5'd7, 5'd0, 5'd8, 32'hFFFFFFE5, 1'b1, 32'h10);
    expect_word(32'h3C09ABCD, 32'h14, 1'b1);
    send(K_ALU, 4'b0101, 4'd0, 5'd0, 5'd0, 5'd9, 32'hABCD0000, 1'b1, 32'h14);
    expect_word(32'h3864FFFF, 32'h18, 1'b1);
    send(K_ALU, 4'b0010, 4'd0, 5'd3, 5'd0, 5'd4, 32'h0000FFFF, 1'b1, 32'h18);
    expect_word(32'hACC50010, 32'h1C, 1'b1);
    send(K_STORE, 4'b0000, 4'd0, 5'd6, 5'd5, 5'd0, 32'h10, 1'b0, 32'h1C);
    drain();

    // Load with wide offset: longest (4-word) sequence
    expect_word(32'h3C010001, 32'h200, 1'b0);
    expect_word(32'h34212340, 32'h204, 1'b0);
    expect_word(32'h00220820, 32'h208, 1'b0);
    expect_word(32'h8C230000, 32'h20C, 1'b1);
    send(K_LOAD, 4'b0000, 4'd0, 5'd2, 5'd0, 5'd3, 32'h00012340, 1'b0, 32'h200);
    drain();

    expect_word(32'h0C100040, 32'h00400000, 1'b1);
    send(K_JAL, 4'b0000, 4'd0, 5'd0, 5'd0, 5'd0, 32'h00400100, 1'b0, 32'h00400000);
    expect_word(32'h03E00008, 32'h24, 1'b1);
    send(K_JR, 4'b0000, 4'd0, 5'd31, 5'd0, 5'd0, 32'h0, 1'b0, 32'h24);
    expect_word(32'h14008000, 32'h0, 1'b1);
    send(K_BRANCH, 4'b0000, 4'd8, 5'd0, 5'd0, 5'd0, 32'hFFFE0004, 1'b0, 32'h0);
    drain();

    // Branch held under back-pressure
    bus.out_ready = 1'b0;
    expect_word(32'h1022FFFB, 32'h100, 1'b1);
    send(K_BRANCH, 4'b0000, 4'd7, 5'd1, 5'd2, 5'd0, 32'hF0, 1'b0, 32'h100);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", 32'(bus.out_valid), 32'd1);
      check("stall_inst", bus.out_inst, 32'h1022FFFB);
      check("stall_pc", bus.out_pc, 32'h100);
    end
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    drain();

    // Rejections
    expect_reject(2'd1);
    send(K_JUMP, 4'b0000, 4'd0, 5'd0, 5'd0, 5'd0, 32'h10000000, 1'b0, 32'h0FFFFFF0);
    reject_tail();
    expect_reject(2'd2);
    send(K_BRANCH, 4'b0000, 4'd7, 5'd1, 5'd2, 5'd0, 32'hF2, 1'b0, 32'h100);
    reject_tail();
    expect_reject(2'd3);
    send(K_LOAD, 4'b0000, 4'd0, 5'd2, 5'd0, 5'd1, 32'h12345678, 1'b0, 32'h0);
    reject_tail();
    expect_reject(2'd1);
    send(K_BRANCH, 4'b0000, 4'd8, 5'd0, 5'd0, 5'd0, 32'h00020004, 1'b0, 32'h0);
    reject_tail();
    expect_reject(2'd3);
    send(K_BRANCH, 4'b0000, 4'd5, 5'd0, 5'd0, 5'd0, 32'hF2, 1'b0, 32'h100);
    reject_tail();
    expect_reject(2'd3);
    send(K_BAD, 4'b0000, 4'd0, 5'd0, 5'd0, 5'd0, 32'h0, 1'b0, 32'h0);
    reject_tail();
    expect_reject(2'd3);
    send(K_ALU, 4'b0011, 4'd0, 5'd2, 5'd3, 5'd4, 32'h3, 1'b0, 32'h0);
    reject_tail();

    // Reset while the second word of an expansion is on the bus
    expect_word(32'h3C011234, 32'h500, 1'b0);
    expect_word(32'h34215678, 32'h504, 1'b0);
    expect_word(32'h00412020, 32'h508, 1'b1);
    send(K_ALU, 4'b0000, 4'd0, 5'd2, 5'd0, 5'd4, 32'h12345678, 1'b1, 32'h500);
    t = 0;
    @(negedge clk);
    while (bus.out_pc !== 32'h504 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("mid_word2_seen", bus.out_pc, 32'h504);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_valid", 32'(bus.out_valid), 32'd0);
    check("mid_rst_last", 32'(bus.out_last), 32'd0);
    check("mid_rst_ready", 32'(bus.in_ready), 32'd1);
    exp_q.delete();
    @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    check("post_rst_ready", 32'(bus.in_ready), 32'd1);
    check("post_rst_valid", 32'(bus.out_valid), 32'd0);

    expect_word(32'h03E00008, 32'h600, 1'b1);
    send(K_JR, 4'b0000, 4'd0, 5'd31, 5'd0, 5'd0, 32'h0, 1'b0, 32'h600);
    drain();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
